mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage bridge between the EX/MEM pipeline register and
// a single-outstanding-request memory port. Each load/store runs
// IDLE (stall) -> BUSY (request out, wait for ack) -> DONE (release pipeline).
// Optional feature macro: MEM_TIMEOUT_EN (BUSY aborts after TIMEOUT_CYCLES
// without ack and sets the sticky mem_err flag).
//
// Handshake: mem_req is a level held, together with mem_we/mem_addr/mem_wdata,
// from the IDLE->BUSY edge until the edge on which mem_ack is sampled high in
// BUSY (or the timeout fires); mem_ack is only meaningful in BUSY and
// mem_rdata is only sampled together with it.
module mem_access_ctrl #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemtoReg_Out,
  input  logic              MemWrite_Out,
  input  logic [ADDR_W-1:0] AluOut,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              mem_err,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t nextState;
  logic   pending;
  logic   timeoutHit;

  assign pending  = MemtoReg_Out | MemWrite_Out;
  assign dbgState = state;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] busyCnt;

  assign timeoutHit = (state == BUSY) && !mem_ack && (busyCnt == TimeoutLast);

  // Count un-acked BUSY cycles; the sticky error flag is only cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busyCnt <= 8'd0;
      mem_err <= 1'b0;
    end else if (state == IDLE && pending) begin
      busyCnt <= 8'd0;
    end else if (state == BUSY && !mem_ack) begin
      if (timeoutHit) mem_err <= 1'b1;
      else            busyCnt <= busyCnt + 8'd1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign mem_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and stall; DONE always returns to IDLE because EX/MEM moves on.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          stall     = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack || timeoutHit) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Memory request registers and load capture; a store wins over a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_Out;
            mem_addr  <= AluOut;
            mem_wdata <= DataOut;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              load_data  <= mem_rdata;
              load_valid <= 1'b1;
            end
          end else if (timeoutHit) begin
            mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl (built with TIMEOUT_CYCLES=4; the
// timeout scenario is selected by MEM_TIMEOUT_EN).
module tb_mem_access_ctrl;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              clk;
  logic              reset;
  logic              MemtoReg_Out;
  logic              MemWrite_Out;
  logic [ADDR_W-1:0] AluOut;
  logic [DATA_W-1:0] DataOut;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              stall;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              mem_err;
  logic [1:0]        dbgState;

  int testsRun;
  int testsFailed;

  mem_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .MemtoReg_Out(MemtoReg_Out), .MemWrite_Out(MemWrite_Out),
    .AluOut(AluOut), .DataOut(DataOut),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .mem_err(mem_err), .dbgState(dbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    MemtoReg_Out = 1'b0;
    MemWrite_Out = 1'b0;
    AluOut       = '0;
    DataOut      = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    tick();
    tick();
    testsRun++;
    if (dbgState !== S_IDLE) begin testsFailed++; $display("FAIL reset_state: got %0d expected %0d", dbgState, S_IDLE); end
    testsRun++;
    if ({mem_req, mem_we, load_valid, mem_err, stall} !== 5'b0) begin
      testsFailed++; $display("FAIL reset_flags: got %05b expected 00000", {mem_req, mem_we, load_valid, mem_err, stall});
    end
    testsRun++;
    if (mem_addr !== '0 || mem_wdata !== '0 || load_data !== '0) begin
      testsFailed++; $display("FAIL reset_data: addr %0h wdata %0h ldata %0h expected 0", mem_addr, mem_wdata, load_data);
    end
    // stall is combinational in IDLE even while reset is held
    MemtoReg_Out = 1'b1;
    #1;
    testsRun++;
    if (stall !== 1'b1) begin testsFailed++; $display("FAIL reset_stall_pending: got %0b expected 1", stall); end
    MemtoReg_Out = 1'b0;
    #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int stallCnt;
    int reqCnt;
    stallCnt = 0;
    reqCnt   = 0;
    MemtoReg_Out = 1'b1;
    AluOut       = 64'h100;
    #1;
    stallCnt += int'(stall);
    reqCnt   += int'(mem_req);
    tick();
    testsRun++;
    if (dbgState !== S_BUSY || mem_addr !== 64'h100 || mem_we !== 1'b0) begin
      testsFailed++; $display("FAIL load_busy: state %0d addr %0h we %0b expected 1 100 0", dbgState, mem_addr, mem_we);
    end
    mem_ack   = 1'b1;
    mem_rdata = 64'hDEADBEEF;
    #1;
    stallCnt += int'(stall);
    reqCnt   += int'(mem_req);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    stallCnt += int'(stall);
    reqCnt   += int'(mem_req);
    testsRun++;
    if (dbgState !== S_DONE || load_valid !== 1'b1 || load_data !== 64'hDEADBEEF) begin
      testsFailed++; $display("FAIL load_done: state %0d valid %0b data %0h expected 2 1 deadbeef", dbgState, load_valid, load_data);
    end
    MemtoReg_Out = 1'b0;
    AluOut       = '0;
    tick();
    stallCnt += int'(stall);
    reqCnt   += int'(mem_req);
    testsRun++;
    if (dbgState !== S_IDLE || load_valid !== 1'b0) begin
      testsFailed++; $display("FAIL load_after: state %0d valid %0b expected 0 0", dbgState, load_valid);
    end
    testsRun++;
    if (stallCnt !== 2) begin testsFailed++; $display("FAIL load_stall_cycles: got %0d expected 2", stallCnt); end
    testsRun++;
    if (reqCnt !== 1) begin testsFailed++; $display("FAIL load_req_cycles: got %0d expected 1", reqCnt); end
  endtask

  task automatic test_store();
    MemWrite_Out = 1'b1;
    AluOut       = 64'h200;
    DataOut      = 64'h55;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ack = 1'b1;
      #1;
      testsRun++;
      if (dbgState !== S_BUSY || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 64'h55 || mem_addr !== 64'h200 || stall !== 1'b1) begin
        testsFailed++;
        $display("FAIL store_hold_%0d: state %0d req %0b we %0b wdata %0h addr %0h stall %0b expected 1 1 1 55 200 1",
                 i, dbgState, mem_req, mem_we, mem_wdata, mem_addr, stall);
      end
      tick();
    end
    mem_ack = 1'b0;
    #1;
    testsRun++;
    if (dbgState !== S_DONE || load_valid !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0 || load_data !== 64'hDEADBEEF) begin
      testsFailed++;
      $display("FAIL store_done: state %0d valid %0b req %0b stall %0b ldata %0h expected 2 0 0 0 deadbeef",
               dbgState, load_valid, mem_req, stall, load_data);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_priority();
    MemtoReg_Out = 1'b1;
    MemWrite_Out = 1'b1;
    AluOut       = 64'h300;
    DataOut      = 64'hA5;
    tick();
    testsRun++;
    if (mem_we !== 1'b1 || mem_req !== 1'b1) begin
      testsFailed++; $display("FAIL priority_we: we %0b req %0b expected 1 1", mem_we, mem_req);
    end
    mem_ack   = 1'b1;
    mem_rdata = 64'h1234;
    tick();
    mem_ack = 1'b0;
    #1;
    testsRun++;
    if (load_valid !== 1'b0 || load_data !== 64'hDEADBEEF) begin
      testsFailed++; $display("FAIL priority_noload: valid %0b data %0h expected 0 deadbeef", load_valid, load_data);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_ack_idle();
    mem_ack   = 1'b1;
    mem_rdata = 64'hBAD;
    tick();
    tick();
    testsRun++;
    if (dbgState !== S_IDLE || load_valid !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0 || load_data !== 64'hDEADBEEF) begin
      testsFailed++;
      $display("FAIL ack_idle: state %0d valid %0b req %0b stall %0b data %0h expected 0 0 0 0 deadbeef",
               dbgState, load_valid, mem_req, stall, load_data);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    MemtoReg_Out = 1'b1;
    AluOut       = 64'h400;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 64'h1111;
    tick();
    // Still in DONE with the same request pending: an ack here is ignored
    testsRun++;
    if (dbgState !== S_DONE || stall !== 1'b0 || load_data !== 64'h1111) begin
      testsFailed++; $display("FAIL b2b_done1: state %0d stall %0b data %0h expected 2 0 1111", dbgState, stall, load_data);
    end
    mem_rdata = 64'h2222;
    AluOut    = 64'h408;
    tick();
    mem_ack = 1'b0;
    #1;
    testsRun++;
    if (dbgState !== S_IDLE || stall !== 1'b1 || mem_req !== 1'b0 || load_data !== 64'h1111) begin
      testsFailed++;
      $display("FAIL b2b_idle: state %0d stall %0b req %0b data %0h expected 0 1 0 1111", dbgState, stall, mem_req, load_data);
    end
    tick();
    testsRun++;
    if (dbgState !== S_BUSY || mem_addr !== 64'h408) begin
      testsFailed++; $display("FAIL b2b_busy2: state %0d addr %0h expected 1 408", dbgState, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    testsRun++;
    if (dbgState !== S_DONE || load_data !== 64'h2222 || load_valid !== 1'b1) begin
      testsFailed++; $display("FAIL b2b_done2: state %0d data %0h valid %0b expected 2 2222 1", dbgState, load_data, load_valid);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_mid_reset();
    MemtoReg_Out = 1'b1;
    AluOut       = 64'h500;
    tick();
    #2;
    reset = 1'b0;
    #1;
    testsRun++;
    if (mem_req !== 1'b0 || dbgState !== S_IDLE || stall !== 1'b1) begin
      testsFailed++; $display("FAIL midreset_async: req %0b state %0d stall %0b expected 0 0 1", mem_req, dbgState, stall);
    end
    drive_idle();
    tick();
    reset = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 64'h7777;
    tick();
    tick();
    mem_ack = 1'b0;
    #1;
    testsRun++;
    if (dbgState !== S_IDLE || load_valid !== 1'b0 || load_data !== '0 || mem_req !== 1'b0) begin
      testsFailed++;
      $display("FAIL midreset_lateack: state %0d valid %0b data %0h req %0b expected 0 0 0 0", dbgState, load_valid, load_data, mem_req);
    end
    drive_idle();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    MemtoReg_Out = 1'b1;
    AluOut       = 64'h600;
    tick();
    tick();
    tick();
    tick();
    testsRun++;
    if (dbgState !== S_BUSY || mem_err !== 1'b0 || mem_req !== 1'b1) begin
      testsFailed++; $display("FAIL timeout_busy3: state %0d err %0b req %0b expected 1 0 1", dbgState, mem_err, mem_req);
    end
    tick();
    testsRun++;
    if (dbgState !== S_DONE || mem_err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b0 || load_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL timeout_done: state %0d err %0b req %0b stall %0b valid %0b expected 2 1 0 0 0",
               dbgState, mem_err, mem_req, stall, load_valid);
    end
    drive_idle();
    tick();
    tick();
    testsRun++;
    if (mem_err !== 1'b1 || dbgState !== S_IDLE) begin
      testsFailed++; $display("FAIL timeout_sticky: err %0b state %0d expected 1 0", mem_err, dbgState);
    end
    reset = 1'b0;
    #1;
    testsRun++;
    if (mem_err !== 1'b0) begin testsFailed++; $display("FAIL timeout_reset: err %0b expected 0", mem_err); end
    tick();
    reset = 1'b1;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    MemtoReg_Out = 1'b1;
    AluOut       = 64'h600;
    tick();
    for (int i = 0; i < 20; i++) tick();
    testsRun++;
    if (dbgState !== S_BUSY || mem_req !== 1'b1 || mem_err !== 1'b0 || stall !== 1'b1) begin
      testsFailed++;
      $display("FAIL no_timeout_wait: state %0d req %0b err %0b stall %0b expected 1 1 0 1", dbgState, mem_req, mem_err, stall);
    end
    mem_ack   = 1'b1;
    mem_rdata = 64'h66;
    tick();
    mem_ack = 1'b0;
    #1;
    testsRun++;
    if (dbgState !== S_DONE || load_valid !== 1'b1 || load_data !== 64'h66) begin
      testsFailed++; $display("FAIL no_timeout_ack: state %0d valid %0b data %0h expected 2 1 66", dbgState, load_valid, load_data);
    end
    drive_idle();
    tick();
  endtask
`endif

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_load();
    test_store();
    test_priority();
    test_ack_idle();
    test_back_to_back();
    test_mid_reset();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
